// File: rtl/bcd_dec_sched_pkg.sv
// Shared constants, state encoding and index-to-code helper for the BCD
// decoder scheduler.
package bcd_sched_pkg;

    localparam int          NUM_REQ   = 9;
    localparam logic [3:0]  CODE_IDLE = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Decoder line i is selected by BCD code i+1; code 0000 blanks all lines.
    function automatic logic [3:0] idx_to_code(input logic [3:0] idx);
        return idx + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_dec_sched_if.sv
// Request/decoder-side signal bundle of the scheduler.
interface bcd_dec_sched_if;
    import bcd_sched_pkg::*;

    logic               en;
    logic [NUM_REQ-1:0] req;
    logic [3:0]         code;
    logic               busy;
    logic [3:0]         cur_idx;
    logic [NUM_REQ-1:0] ack;

    // Request side: drives enable and requests, observes service.
    modport master (
        output en, req,
        input  code, busy, cur_idx, ack
    );

    // Scheduler side.
    modport slave (
        input  en, req,
        output code, busy, cur_idx, ack
    );
endinterface

// File: rtl/bcd_dec_sched_rr_pick9.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping from index 8 back to 0.
module rr_pick9
    import bcd_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [3:0]         ptr,
    output logic               any,
    output logic [3:0]         idx
);

    logic [3:0]         cand [NUM_REQ];
    logic [NUM_REQ-1:0] hit;

    // Candidate gi is the requester gi positions after the pointer (mod 9).
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            logic [4:0] sum;
            assign sum       = {1'b0, ptr} + 5'(gi);
            assign cand[gi]  = (sum >= 5'(NUM_REQ)) ? 4'(sum - 5'(NUM_REQ)) : sum[3:0];
            assign hit[gi]   = req[cand[gi]];
        end
    endgenerate

    // Lowest rotation offset with a live request wins.
    always_comb begin
        any = |hit;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (hit[k]) idx = cand[k];
        end
    end

endmodule

// File: rtl/bcd_dec_sched.sv
// Round-robin scheduler sharing one BCD-to-decimal decoder among 9
// requesters: IDLE -> HOLD (dwell) -> GAP (blank + ack) -> IDLE.
module bcd_dec_sched
    import bcd_sched_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    bcd_dec_sched_if.slave bus
);

    // A dwell of 0 would make no sense; it behaves like a dwell of 1.
    localparam int               HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_EFF - 1);

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [3:0]         ptr_reg;
    logic [3:0]         code_reg;
    logic               busy_reg;
    logic [3:0]         idx_reg;
    logic [NUM_REQ-1:0] ack_reg;

    logic               pick_any;
    logic [3:0]         pick_idx;

    rr_pick9 u_pick (
        .req (bus.req),
        .ptr (ptr_reg),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Scheduler FSM with dwell counter, fairness pointer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            ptr_reg   <= '0;
            code_reg  <= CODE_IDLE;
            busy_reg  <= 1'b0;
            idx_reg   <= '0;
            ack_reg   <= '0;
        end else begin
            ack_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.en && pick_any) begin
                        state_reg <= ST_HOLD;
                        code_reg  <= idx_to_code(pick_idx);
                        idx_reg   <= pick_idx;
                        busy_reg  <= 1'b1;
                        cnt_reg   <= CNT_LOAD;
                    end else begin
                        code_reg  <= CODE_IDLE;
                        busy_reg  <= 1'b0;
                        idx_reg   <= '0;
                    end
                end
                ST_HOLD: begin
                    if (cnt_reg == '0) begin
                        // Dwell done: blank the decoder and pulse ack for one cycle.
                        state_reg        <= ST_GAP;
                        code_reg         <= CODE_IDLE;
                        ack_reg[idx_reg] <= 1'b1;
                        ptr_reg          <= (idx_reg == 4'(NUM_REQ - 1)) ? 4'd0 : idx_reg + 4'd1;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_GAP: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    idx_reg   <= '0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    code_reg  <= CODE_IDLE;
                    busy_reg  <= 1'b0;
                    idx_reg   <= '0;
                end
            endcase
        end
    end

    assign bus.code    = code_reg;
    assign bus.busy    = busy_reg;
    assign bus.cur_idx = idx_reg;
    assign bus.ack     = ack_reg;

endmodule

// File: tb/tb_bcd_dec_sched.sv
// Scoreboard bench: three scheduler instances (dwell 4, 2, 1) share clock
// and reset; stimulus pushes expected services, a monitor checks each ack.
module tb_bcd_dec_sched;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    bcd_dec_sched_if bus0 ();
    bcd_dec_sched_if bus1 ();
    bcd_dec_sched_if bus2 ();

    bcd_dec_sched #(.HOLD_CYCLES(4), .CNT_W(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    bcd_dec_sched #(.HOLD_CYCLES(2), .CNT_W(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    bcd_dec_sched #(.HOLD_CYCLES(1), .CNT_W(16)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    logic [3:0] code_m [3];
    logic [3:0] cur_m  [3];
    logic       busy_m [3];
    logic [8:0] ack_m  [3];

    assign code_m[0] = bus0.code;  assign cur_m[0] = bus0.cur_idx;
    assign busy_m[0] = bus0.busy;  assign ack_m[0] = bus0.ack;
    assign code_m[1] = bus1.code;  assign cur_m[1] = bus1.cur_idx;
    assign busy_m[1] = bus1.busy;  assign ack_m[1] = bus1.ack;
    assign code_m[2] = bus2.code;  assign cur_m[2] = bus2.cur_idx;
    assign busy_m[2] = bus2.busy;  assign ack_m[2] = bus2.ack;

    typedef struct {
        int d;       // which instance
        int idx;     // requester served
        int hold;    // cycles code must be non-zero
        int period;  // start-to-start distance from previous service, 0 = unchecked
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic drive(input int d, input logic en, input logic [8:0] req);
        case (d)
            0: begin bus0.en = en; bus0.req = req; end
            1: begin bus1.en = en; bus1.req = req; end
            default: begin bus2.en = en; bus2.req = req; end
        endcase
    endtask

    task automatic expect_srv(input int d, input int idx, input int hold, input int period);
        exp_t e;
        e.d = d; e.idx = idx; e.hold = hold; e.period = period;
        exp_q.push_back(e);
    endtask

    task automatic wait_serving(input int d, input int idx);
        bit ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (busy_m[d] && code_m[d] != 4'd0 && int'(cur_m[d]) == idx) ok = 1'b1;
        end
        chk($sformatf("wait_serve_d%0d_i%0d", d, idx), int'(ok), 1);
    endtask

    task automatic wait_idle(input int d);
        bit ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (!busy_m[d] && code_m[d] == 4'd0) ok = 1'b1;
        end
        chk($sformatf("wait_idle_d%0d", d), int'(ok), 1);
    endtask

    // Monitor: follows each code run and settles it against the scoreboard at ack.
    int run_len [3];
    int run_code[3];
    int run_idx [3];
    int start_c [3];
    int prev_st [3];
    int last_nz [3];

    initial begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            run_len[d] = 0; run_code[d] = 0; run_idx[d] = 0;
            start_c[d] = 0; prev_st[d] = 0; last_nz[d] = 0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                for (int d = 0; d < 3; d++) run_len[d] = 0;
            end else begin
                for (int d = 0; d < 3; d++) begin
                    if (code_m[d] > 4'd9) chk($sformatf("code_range_d%0d", d), int'(code_m[d]), 0);
                    if (ack_m[d] != 9'd0) begin
                        if (exp_q.size() == 0) begin
                            chk($sformatf("unexpected_ack_d%0d", d), int'(ack_m[d]), 0);
                        end else begin
                            e = exp_q.pop_front();
                            $display("ack d%0d ack=%b idx=%0d dwell=%0d cyc=%0d", d, ack_m[d], run_idx[d], run_len[d], cyc);
                            chk("ack_inst",  d, e.d);
                            chk("ack_vec",   int'(ack_m[d]), 1 << e.idx);
                            chk("gap_code",  int'(code_m[d]), 0);
                            chk("gap_busy",  int'(busy_m[d]), 1);
                            chk("srv_idx",   run_idx[d], e.idx);
                            chk("srv_code",  run_code[d], e.idx + 1);
                            chk("dwell",     run_len[d], e.hold);
                            chk("ack_delay", cyc - last_nz[d], 1);
                            if (e.period != 0) chk("period", start_c[d] - prev_st[d], e.period);
                        end
                        run_len[d] = 0;
                    end else if (code_m[d] != 4'd0) begin
                        if (run_len[d] == 0) begin
                            prev_st[d]  = start_c[d];
                            start_c[d]  = cyc;
                            run_code[d] = int'(code_m[d]);
                            run_idx[d]  = int'(cur_m[d]);
                        end else if (int'(code_m[d]) != run_code[d]) begin
                            chk($sformatf("code_stable_d%0d", d), int'(code_m[d]), run_code[d]);
                        end
                        run_len[d]++;
                        last_nz[d] = cyc;
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 9'd0);
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_code_d%0d", d), int'(code_m[d]), 0);
            chk($sformatf("rst_busy_d%0d", d), int'(busy_m[d]), 0);
            chk($sformatf("rst_ack_d%0d",  d), int'(ack_m[d]),  0);
            chk($sformatf("rst_idx_d%0d",  d), int'(cur_m[d]),  0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Single request on line 4, dwell 4.
        expect_srv(0, 4, 4, 0);
        drive(0, 1'b1, 9'b000010000);
        wait_serving(0, 4);
        drive(0, 1'b1, 9'd0);
        wait_idle(0);
        @(negedge clk);
        chk("busy_after_single", int'(busy_m[0]), 0);

        // Fairness: pointer is 5; serve 3, then 5 must beat 2.
        expect_srv(0, 3, 4, 0);
        expect_srv(0, 5, 4, 0);
        expect_srv(0, 2, 4, 0);
        drive(0, 1'b1, 9'b000001000);
        wait_serving(0, 3);
        drive(0, 1'b1, 9'b000100100);
        wait_serving(0, 5);
        drive(0, 1'b1, 9'b000000100);
        wait_serving(0, 2);
        drive(0, 1'b1, 9'd0);
        wait_idle(0);

        // Reset in the middle of serving 6: no ack, pointer back to 0.
        drive(0, 1'b1, 9'b001000000);
        wait_serving(0, 6);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_code", int'(code_m[0]), 0);
        chk("midrst_busy", int'(busy_m[0]), 0);
        chk("midrst_ack",  int'(ack_m[0]),  0);
        drive(0, 1'b1, 9'b010000010);
        expect_srv(0, 1, 4, 0);
        expect_srv(0, 7, 4, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_serving(0, 1);
        drive(0, 1'b1, 9'b010000000);

        // en and req[7] dropped during the dwell of 7; other requests pending.
        wait_serving(0, 7);
        drive(0, 1'b0, 9'b000001001);
        wait_idle(0);
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            chk("en_low_code", int'(code_m[0]), 0);
            chk("en_low_busy", int'(busy_m[0]), 0);
        end
        drive(0, 1'b0, 9'd0);

        // All requests held, dwell 2: indices 0..8 then 0, four cycles apart.
        for (int k = 0; k < 10; k++) expect_srv(1, k % 9, 2, (k == 0) ? 0 : 4);
        drive(1, 1'b1, 9'h1FF);
        for (int k = 0; k < 10; k++) begin
            wait_serving(1, k % 9);
            if (k == 9) drive(1, 1'b1, 9'd0);
        end
        wait_idle(1);

        // Dwell 1 on line 8.
        expect_srv(2, 8, 1, 0);
        drive(2, 1'b1, 9'b100000000);
        wait_serving(2, 8);
        drive(2, 1'b1, 9'd0);
        wait_idle(2);
        repeat (4) @(negedge clk);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
